xm_stage_buf: RTL and testbench
===============================

XM_STAGE_BUF -- requirements
Module: xm_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of alu_out/pc1/xm_o; minimum 32.
REQ-002 SHALL have parameter REG_AW, default 5, width of xm_rd; minimum 5.
REQ-003 SHALL have parameter LINK_REG, default 31, destination for jal.
REQ-004 SHALL have parameter STATUS_REG, default 30, destination for setx and exceptions.
REQ-005 SHALL have parameter CNT_W, default 8, width of exc_count.
REQ-006 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1: upstream handshake.
REQ-009 SHALL have ports ir input 32, alu_out input DATA_W, pc1 input DATA_W, exception input 1: DX result.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-011 SHALL have ports xm_rd output REG_AW, xm_o output DATA_W, xm_ir output 32, exc_flag output 1.
REQ-012 SHALL have port flush input 1: synchronous pipeline kill.
REQ-013 SHALL have port exc_count output CNT_W: emitted-exception count.

Function
REQ-014 SHALL decode opcode=ir[31:27], aluop=ir[6:2], T=ir[26:0] zero-extended to DATA_W.
REQ-015 SHALL classify: jal=00011, addi=00101, setx=10101, rexc=(opcode 00000 and aluop in {00000,00001,00110,00111}).
REQ-016 SHALL set rd: setx or (exception and (addi or rexc)) -> STATUS_REG; else jal -> LINK_REG; else ir[26:22], zero-extended to REG_AW.
REQ-017 SHALL set o, priority high to low: setx -> T; jal -> pc1; addi and exception -> 2; rexc and exception -> 1/3/4/5 for aluop[1:0]=00/01/10/11; else alu_out.
REQ-018 SHALL set exc_flag=1 only when exception and (addi or rexc).
REQ-019 SHALL buffer {rd,o,ir,exc_flag} in a 2-entry skid buffer (main, skid); main drives outputs.
REQ-020 SHALL make in_ready a register, equal to "skid entry empty".
REQ-021 SHALL accept on in_valid and in_ready; latency accept->out_valid is 1 cycle when main is empty or draining.
REQ-022 SHALL emit on out_valid and out_ready; outputs stable while out_valid and not out_ready.
REQ-023 SHALL, on accept with main full and not draining, store to skid; in_ready drops next cycle.
REQ-024 SHALL, with both full and out_ready, move skid to main; in_ready rises next cycle.
REQ-025 SHALL, with accept and emit in the same cycle and skid empty, load the new entry into main without a bubble.
REQ-026 SHALL preserve order; no entry dropped or duplicated except by flush.
REQ-027 SHALL on flush clear both valids next cycle, set in_ready=1, and drop any same-cycle input; flush outranks accept and emit.

Reset
REQ-028 SHALL on reset_n low asynchronously force out_valid=0, skid empty, in_ready=1, xm_rd=0, xm_o=0, xm_ir=0, exc_flag=0, exc_count=0.
REQ-029 SHALL resume normal operation on the first rising clock edge after reset_n deasserts; reset mid-transfer discards all entries.

Configuration
REQ-030 SHALL use macro XM_EXC_COUNT_EN: when defined, exc_count increments by 1 per emitted entry with exc_flag=1 and saturates at all-ones; it is unaffected by flush and cleared only by reset.
REQ-031 SHALL, when XM_EXC_COUNT_EN is undefined, keep port exc_count, tie it to 0, and infer no counter logic.

Verification
REQ-032 SHALL test: ir opcode 00011, pc1=0x40, out_ready=1 -> next cycle out_valid=1, xm_rd=31, xm_o=0x40.
REQ-033 SHALL test: ir opcode 00000 aluop 00111 with exception=1 -> xm_rd=30, xm_o=5, exc_flag=1; same with exception=0 -> xm_rd=ir[26:22], xm_o=alu_out.
REQ-034 SHALL test: setx with ir[26:0]=0x1234567 -> xm_rd=30, xm_o=0x01234567; addi with exception -> xm_o=2.
REQ-035 SHALL test: out_ready=0, 3 back-to-back valids A,B,C -> A in main, B in skid, in_ready=0, C held; out_ready=1 -> A,B,C emitted in order, no bubble after A.
REQ-036 SHALL test: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input not emitted; reset_n pulse mid-stream -> all outputs 0.
REQ-037 SHALL test: with XM_EXC_COUNT_EN, CNT_W=2, 5 emitted exceptions -> exc_count=3 (saturated); macro undefined -> exc_count=0.

Source files
------------

// File: rtl/xm_stage_buf.sv
// X/M stage buffer: decodes the DX result (jal/setx/exception rewrites) and holds it in a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when main is empty or draining. Backpressure: in_ready is registered, low only while skid is occupied.
// Optional: define XM_EXC_COUNT_EN to count emitted exception entries on exc_count (otherwise tied to 0).
module xm_stage_buf #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30,
    parameter int CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] pc1,
    input  logic              exception,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] xm_rd,
    output logic [DATA_W-1:0] xm_o,
    output logic [31:0]       xm_ir,
    output logic              exc_flag,
    input  logic              flush,
    output logic [CNT_W-1:0]  exc_count
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] o;
        logic [31:0]       ir;
        logic              exc;
    } entry_t;

    logic [4:0]  opcode;
    logic [4:0]  aluop;
    logic        is_jal;
    logic        is_addi;
    logic        is_setx;
    logic        is_rexc;
    logic        exc_hit;
    entry_t      new_ent;

    assign opcode  = ir[31:27];
    assign aluop   = ir[6:2];
    assign is_jal  = (opcode == 5'b00011);
    assign is_addi = (opcode == 5'b00101);
    assign is_setx = (opcode == 5'b10101);
    assign is_rexc = (opcode == 5'b00000) &&
                     ((aluop == 5'b00000) || (aluop == 5'b00001) ||
                      (aluop == 5'b00110) || (aluop == 5'b00111));
    assign exc_hit = exception && (is_addi || is_rexc);

    always_comb begin
        new_ent.ir  = ir;
        new_ent.exc = exc_hit;
        if (is_setx || exc_hit)
            new_ent.rd = REG_AW'(STATUS_REG);
        else if (is_jal)
            new_ent.rd = REG_AW'(LINK_REG);
        else
            new_ent.rd = REG_AW'(ir[26:22]);
        // Exception codes: addi overflow = 2, R-type by aluop[1:0] = 1/3/4/5
        if (is_setx)
            new_ent.o = DATA_W'(ir[26:0]);
        else if (is_jal)
            new_ent.o = pc1;
        else if (is_addi && exception)
            new_ent.o = DATA_W'(2);
        else if (is_rexc && exception) begin
            case (aluop[1:0])
                2'b00:   new_ent.o = DATA_W'(1);
                2'b01:   new_ent.o = DATA_W'(3);
                2'b10:   new_ent.o = DATA_W'(4);
                default: new_ent.o = DATA_W'(5);
            endcase
        end else
            new_ent.o = alu_out;
    end

    entry_t main_q;
    entry_t skid_q;
    logic   main_vld;
    logic   skid_vld;
    logic   in_ready_q;
    logic   accept;
    logic   emit;
    logic   main_drain;
    logic   main_vld_nxt;
    logic   skid_vld_nxt;
    logic   ld_main_skid;
    logic   ld_main_new;
    logic   ld_skid;

    assign accept     = in_valid && in_ready_q;
    assign emit       = main_vld && out_ready;
    assign main_drain = !main_vld || out_ready;

    always_comb begin
        main_vld_nxt = main_vld;
        skid_vld_nxt = skid_vld;
        ld_main_skid = 1'b0;
        ld_main_new  = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            main_vld_nxt = 1'b0;
            skid_vld_nxt = 1'b0;
        end else if (main_drain) begin
            // in_ready is low whenever skid holds data, so no accept can race the skid move
            if (skid_vld) begin
                ld_main_skid = 1'b1;
                main_vld_nxt = 1'b1;
                skid_vld_nxt = 1'b0;
            end else if (accept) begin
                ld_main_new  = 1'b1;
                main_vld_nxt = 1'b1;
            end else begin
                main_vld_nxt = 1'b0;
            end
        end else if (accept) begin
            ld_skid      = 1'b1;
            skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_vld   <= main_vld_nxt;
            skid_vld   <= skid_vld_nxt;
            in_ready_q <= !skid_vld_nxt;
            if (ld_main_skid)
                main_q <= skid_q;
            else if (ld_main_new)
                main_q <= new_ent;
            if (ld_skid)
                skid_q <= new_ent;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign xm_rd     = main_q.rd;
    assign xm_o      = main_q.o;
    assign xm_ir     = main_q.ir;
    assign exc_flag  = main_q.exc;

`ifdef XM_EXC_COUNT_EN
    logic [CNT_W-1:0] exc_cnt_q;

    // Counts downstream handshakes carrying an exception; saturates, survives flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            exc_cnt_q <= '0;
        else if (emit && main_q.exc && (exc_cnt_q != {CNT_W{1'b1}}))
            exc_cnt_q <= exc_cnt_q + CNT_W'(1);
    end

    assign exc_count = exc_cnt_q;
`else
    assign exc_count = '0;
`endif

endmodule

// File: tb/tb_xm_stage_buf.sv
// Bench for xm_stage_buf: directed decode/skid/flush/reset cases plus randomized traffic against a queue-based model.
module tb_xm_stage_buf;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir;
    logic [31:0] alu_out;
    logic [31:0] pc1;
    logic        exception;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  xm_rd;
    logic [31:0] xm_o;
    logic [31:0] xm_ir;
    logic        exc_flag;
    logic        flush;
    logic [1:0]  exc_count;

    int n_tests;
    int n_fail;
    int exc_emitted;

    xm_stage_buf #(.DATA_W(32), .REG_AW(5), .LINK_REG(31), .STATUS_REG(30), .CNT_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .alu_out(alu_out), .pc1(pc1), .exception(exception),
        .out_valid(out_valid), .out_ready(out_ready), .xm_rd(xm_rd), .xm_o(xm_o),
        .xm_ir(xm_ir), .exc_flag(exc_flag), .flush(flush), .exc_count(exc_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] o;
        logic [31:0] ir;
        logic        exc;
    } exp_t;

    // Reference: the architectural rewrite rules written out directly
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] alu,
                                   input logic [31:0] pc, input logic e);
        exp_t r;
        int op;
        int aop;
        bit jal, addi, setx, rexc, hit;
        int codes[4];
        codes = '{1, 3, 4, 5};
        op   = int'(i[31:27]);
        aop  = int'(i[6:2]);
        jal  = (op == 3);
        addi = (op == 5);
        setx = (op == 21);
        rexc = (op == 0) && (aop == 0 || aop == 1 || aop == 6 || aop == 7);
        hit  = e && (addi || rexc);
        r.ir  = i;
        r.exc = hit;
        r.rd  = (setx || hit) ? 5'd30 : (jal ? 5'd31 : i[26:22]);
        if (setx)              r.o = {5'd0, i[26:0]};
        else if (jal)          r.o = pc;
        else if (addi && e)    r.o = 32'd2;
        else if (rexc && e)    r.o = 32'(codes[aop % 4]);
        else                   r.o = alu;
        return r;
    endfunction

    function automatic int exp_count(input int n);
`ifdef XM_EXC_COUNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    task automatic idle_inputs();
        in_valid  = 1'b0;
        ir        = '0;
        alu_out   = '0;
        pc1       = '0;
        exception = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        exc_emitted = 0;
        @(negedge clock);
    endtask

    // Present one entry for one accept with out_ready high; returns at the negedge where it sits in main
    task automatic send_one(input logic [31:0] i, input logic [31:0] alu,
                            input logic [31:0] pc, input logic e);
        in_valid = 1'b1; ir = i; alu_out = alu; pc1 = pc; exception = e; out_ready = 1'b1;
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_reset();
        n_tests++;
        if ({out_valid, in_ready, xm_rd, xm_o, xm_ir, exc_flag, exc_count} !== {1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: ov=%b ir=%b rd=%0d o=%h xir=%h exc=%b cnt=%0d, need ov=0 ir=1 rest 0",
                     out_valid, in_ready, xm_rd, xm_o, xm_ir, exc_flag, exc_count);
        end
    endtask

    task automatic test_jal();
        send_one({5'b00011, 27'h0}, 32'hdead, 32'h40, 1'b0);
        n_tests++;
        if ({out_valid, xm_rd, xm_o, exc_flag} !== {1'b1, 5'd31, 32'h40, 1'b0}) begin
            n_fail++;
            $display("FAIL jal: ov=%b rd=%0d o=%h exc=%b, need 1/31/40/0", out_valid, xm_rd, xm_o, exc_flag);
        end
        @(negedge clock);
    endtask

    task automatic test_rexc();
        logic [31:0] i;
        i = {5'b00000, 5'd9, 15'h0, 5'b00111, 2'b00};
        send_one(i, 32'h1111, 32'h0, 1'b1);
        exc_emitted++;
        n_tests++;
        if ({xm_rd, xm_o, exc_flag, xm_ir} !== {5'd30, 32'd5, 1'b1, i}) begin
            n_fail++;
            $display("FAIL rexc_exc: rd=%0d o=%h exc=%b, need 30/5/1", xm_rd, xm_o, exc_flag);
        end
        @(negedge clock);
        send_one(i, 32'h2222, 32'h0, 1'b0);
        n_tests++;
        if ({xm_rd, xm_o, exc_flag} !== {5'd9, 32'h2222, 1'b0}) begin
            n_fail++;
            $display("FAIL rexc_noexc: rd=%0d o=%h exc=%b, need 9/2222/0", xm_rd, xm_o, exc_flag);
        end
        @(negedge clock);
    endtask

    task automatic test_setx_addi();
        send_one({5'b10101, 27'h1234567}, 32'h3333, 32'h0, 1'b0);
        n_tests++;
        if ({xm_rd, xm_o, exc_flag} !== {5'd30, 32'h01234567, 1'b0}) begin
            n_fail++;
            $display("FAIL setx: rd=%0d o=%h exc=%b, need 30/01234567/0", xm_rd, xm_o, exc_flag);
        end
        @(negedge clock);
        send_one({5'b00101, 5'd3, 22'h0}, 32'h4444, 32'h0, 1'b1);
        exc_emitted++;
        n_tests++;
        if ({xm_rd, xm_o, exc_flag} !== {5'd30, 32'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL addi_exc: rd=%0d o=%h exc=%b, need 30/2/1", xm_rd, xm_o, exc_flag);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c;
        a = {5'b00001, 5'd1, 22'h0};
        b = {5'b00001, 5'd2, 22'h0};
        c = {5'b00001, 5'd3, 22'h0};
        out_ready = 1'b0;
        in_valid = 1'b1; ir = a; alu_out = 32'hA;
        @(negedge clock);
        ir = b; alu_out = 32'hB;
        @(negedge clock);
        ir = c; alu_out = 32'hC;
        n_tests++;
        if ({out_valid, in_ready, xm_o} !== {1'b1, 1'b0, 32'hA}) begin
            n_fail++;
            $display("FAIL skid_full: ov=%b in_ready=%b o=%h, need 1/0/A", out_valid, in_ready, xm_o);
        end
        @(negedge clock);
        n_tests++;
        if ({out_valid, in_ready, xm_o} !== {1'b1, 1'b0, 32'hA}) begin
            n_fail++;
            $display("FAIL skid_hold: ov=%b in_ready=%b o=%h, need 1/0/A", out_valid, in_ready, xm_o);
        end
        out_ready = 1'b1;
        @(negedge clock);
        n_tests++;
        if ({out_valid, in_ready, xm_o} !== {1'b1, 1'b1, 32'hB}) begin
            n_fail++;
            $display("FAIL b2b_b: ov=%b in_ready=%b o=%h, need 1/1/B", out_valid, in_ready, xm_o);
        end
        @(negedge clock);
        idle_inputs();
        n_tests++;
        if ({out_valid, xm_o, xm_rd} !== {1'b1, 32'hC, 5'd3}) begin
            n_fail++;
            $display("FAIL b2b_c: ov=%b o=%h rd=%0d, need 1/C/3", out_valid, xm_o, xm_rd);
        end
        @(negedge clock);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: ov=%b, need 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; ir = {5'b00011, 27'h0}; pc1 = 32'h100;
        @(negedge clock);
        pc1 = 32'h104;
        @(negedge clock);
        flush = 1'b1; pc1 = 32'h108;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_pre: ov=%b in_ready=%b, need 1/0", out_valid, in_ready);
        end
        @(negedge clock);
        idle_inputs();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_clear: ov=%b in_ready=%b, need 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_noemit: cycle %0d ov=%b o=%h, need ov=0", k, out_valid, xm_o);
            end
        end
        // Asynchronous reset in the middle of a held transfer
        out_ready = 1'b0;
        in_valid = 1'b1; ir = {5'b00011, 27'h0}; pc1 = 32'h200;
        @(negedge clock);
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, xm_rd, xm_o, xm_ir, exc_flag, exc_count} !== {1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL midreset: ov=%b ir=%b rd=%0d o=%h xir=%h exc=%b cnt=%0d, need 0/1/0...",
                     out_valid, in_ready, xm_rd, xm_o, xm_ir, exc_flag, exc_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        exc_emitted = 0;
        @(negedge clock);
    endtask

    task automatic test_exc_count();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_one({5'b00101, 5'd4, 22'h0}, 32'h0, 32'h0, 1'b1);
            @(negedge clock);
            exc_emitted++;
            if (k == 1) begin
                n_tests++;
                if (int'(exc_count) !== exp_count(exc_emitted)) begin
                    n_fail++;
                    $display("FAIL exc_count_2: got %0d need %0d", exc_count, exp_count(exc_emitted));
                end
            end
        end
        n_tests++;
        if (int'(exc_count) !== exp_count(exc_emitted)) begin
            n_fail++;
            $display("FAIL exc_count_sat: got %0d need %0d", exc_count, exp_count(exc_emitted));
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic [4:0] ops[5];
        logic [4:0] aops[6];
        logic acc, emt;
        ops  = '{5'b00000, 5'b00011, 5'b00101, 5'b10101, 5'b01000};
        aops = '{5'b00000, 5'b00001, 5'b00110, 5'b00111, 5'b00010, 5'b01001};
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            n_tests++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rnd_hs: cyc %0d ov=%b in_ready=%b, model depth %0d", cyc, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                n_tests++;
                if ({xm_rd, xm_o, xm_ir, exc_flag} !== q[0]) begin
                    n_fail++;
                    $display("FAIL rnd_data: cyc %0d rd=%0d o=%h ir=%h exc=%b, need rd=%0d o=%h ir=%h exc=%b",
                             cyc, xm_rd, xm_o, xm_ir, exc_flag, q[0].rd, q[0].o, q[0].ir, q[0].exc);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ir        = $urandom;
            ir[31:27] = ops[$urandom_range(0, 4)];
            ir[6:2]   = aops[$urandom_range(0, 5)];
            alu_out   = $urandom;
            pc1       = $urandom;
            exception = $urandom_range(0, 1) == 1;
            acc = in_valid && (q.size() < 2);
            emt = out_ready && (q.size() > 0);
            e = model(ir, alu_out, pc1, exception);
            if (emt) begin
                if (q[0].exc) exc_emitted++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
            @(negedge clock);
        end
        idle_inputs();
        n_tests++;
        if (int'(exc_count) !== exp_count(exc_emitted)) begin
            n_fail++;
            $display("FAIL rnd_exc_count: got %0d need %0d", exc_count, exp_count(exc_emitted));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        exc_emitted = 0;
        idle_inputs();
        out_ready = 1'b0;
        reset_n = 1'b0;
        #12;
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_jal();
        test_rexc();
        test_setx_addi();
        n_tests++;
        if (int'(exc_count) !== exp_count(exc_emitted)) begin
            n_fail++;
            $display("FAIL exc_count_directed: got %0d need %0d", exc_count, exp_count(exc_emitted));
        end
        test_back_to_back();
        test_flush();
        test_exc_count();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
